dnn_input_buf: RTL
==================

Name: dnn_input_buf

Overview:
- Receiving end of the normalizer output stream (dv/vec/index).
- Collects one complete DNN input vector of INFRAME*IDIM normalized coefficients into a ping-pong buffer of two banks.
- Serves random-access reads to the DNN layer engine, which releases each bank after use.
- Sits between the feature normalizer and the first DNN layer MAC engine.

Parameters:
- OBIT, 13, width of a signed normalized coefficient.
- INFRAME, 5, frames per DNN input vector.
- IDIM, 12, coefficients per frame.
- NVEC, INFRAME*IDIM (60), words per input vector; must be at most 128.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dv_i  in  1  stream word valid; held high for NVEC contiguous cycles per vector.
- vec_i  in  OBIT  signed coefficient, frame-major order (frame 0 dims 0..IDIM-1, then frame 1, ...).
- index_i  in  8  stream index; word k carries (k+1) mod NVEC.
- vec_rdy_o  out  1  a full bank is available to the reader.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  7  word address 0..NVEC-1 within the current read bank.
- rd_data_o  out  OBIT  read data.
- rd_dv_o  out  1  rd_data_o valid.
- rel_i  in  1  one-cycle pulse; reader releases the current read bank.
- drop_o  out  1  one-cycle pulse; a whole incoming vector was discarded because both banks were full.
- err_o  out  1  one-cycle pulse; protocol error, partial vector discarded.
- fill_o  out  2  number of full banks (0..2).

Behaviour:
- Reset: vec_rdy_o=0, rd_dv_o=0, rd_data_o=0, drop_o=0, err_o=0, fill_o=0. Both banks empty, wr_bank=0, rd_bank=0, word counter=0, write FSM in W_IDLE. Reset mid-fill discards the partial vector.
- Write FSM states:
  - W_IDLE: on dv_i=1 with index_i=1, go to W_FILL if bank wr_bank is empty; write word 0, wcnt<=1. If both banks are full, go to W_DROP and pulse drop_o. On dv_i=1 with index_i other than 1, pulse err_o and stay in W_IDLE.
  - W_FILL: each cycle expects dv_i=1 and index_i==(wcnt+1) mod NVEC; writes vec_i to bank[wr_bank][wcnt]. At wcnt==NVEC-1 (index_i=0), mark the bank full, toggle wr_bank, wcnt<=0, go to W_IDLE. If dv_i=0 or the index mismatches, pulse err_o, leave the bank empty, wcnt<=0, go to W_IDLE. A mismatching word is not written.
  - W_DROP: ignore words while dv_i=1; go to W_IDLE on the first dv_i=0.
- Read side:
  - vec_rdy_o = bank[rd_bank] full.
  - rd_en_i with vec_rdy_o=1 returns bank[rd_bank][rd_addr_i] on rd_data_o with rd_dv_o=1 exactly one cycle later.
  - rd_en_i with vec_rdy_o=0, or rd_addr_i>=NVEC, gives rd_dv_o=0 and rd_data_o unchanged.
  - rel_i with vec_rdy_o=1 marks the bank empty and toggles rd_bank. rel_i with vec_rdy_o=0 is ignored.
  - rd_en_i and rel_i in the same cycle: the read is serviced from the bank being released.
- Boundary conditions:
  - Write completion and rel_i in the same cycle both take effect; fill_o stays unchanged.
  - fill_o updates one cycle after the causing event.
  - A vector completing into the second bank while the reader holds the first makes fill_o=2.
  - Latency from the last word written to vec_rdy_o=1 (when the read bank was empty) is 1 cycle.
- Arithmetic: data is stored unmodified; there is no saturation and no sign change.

Decomposition:
- Shared package holds the OBIT/INFRAME/IDIM defaults, NVEC, the write FSM state encodings (W_IDLE, W_FILL, W_DROP), and the index width constant (8).
- One sub-module: dnn_buf_bank, a single-port-write / single-port-read synchronous RAM of NVEC x OBIT with registered read, instantiated twice.
- Bank full flags, pointers and FSMs live in the top.

Test Plan:
- Single vector: vec word k = 3k-90 with index (k+1) mod 60, then read addrs 0, 59 and 17. Expect vec_rdy_o=1 one cycle after word 59, reads of -90, 87, -39 each with 1-cycle latency, fill_o=1; after rel_i, vec_rdy_o=0 and fill_o=0.
- Three back-to-back vectors (values 100+k, 200+k, 300+k) with no releases: fill_o=2, and drop_o pulses once at the third vector's first word. After two releases, reads return 100+k then 200+k, and 300+k is never seen.
- Index error: word 10 carries index 12. Expect err_o pulse that cycle, bank not full, fill_o=0. The next clean vector is accepted into bank 0.
- dv_i gap: dv_i=0 after word 29. Expect err_o pulse, partial vector discarded, the subsequent full vector is read back correctly.
- rst asserted at word 40 of the second vector while bank 0 is full: all outputs return to reset values, fill_o=0, and the next vector lands in bank 0.
- Simultaneous rel_i and word 59 of the second vector: fill_o stays 1, vec_rdy_o stays 1, and reads return the second vector's data.

Source files
------------

// File: rtl/dnn_input_buf_pkg.sv
// Shared sizing constants and write-FSM encoding for the DNN input ping-pong buffer.
package dnn_input_buf_pkg;

   localparam int OBIT_DEF    = 13;                     // signed coefficient width
   localparam int INFRAME_DEF = 5;                      // frames per input vector
   localparam int IDIM_DEF    = 12;                     // coefficients per frame
   localparam int NVEC_DEF    = INFRAME_DEF * IDIM_DEF; // words per input vector (<= 128)
   localparam int IDX_W       = 8;                      // stream index width
   localparam int ADDR_W      = 7;                      // word address width within a bank

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } wstate_t;

endpackage

// File: rtl/dnn_buf_bank.sv
// One bank of the ping-pong buffer: simple dual-port RAM with registered read.
module dnn_buf_bank #(
   parameter int DEPTH = 60,
   parameter int WIDTH = 13,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port; callers guarantee addresses stay below DEPTH.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Registered read port; output holds its value between reads.
   always_ff @(posedge clk) begin
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/dnn_input_buf.sv
// Collects normalized coefficient vectors into two banks and serves random reads to the DNN engine.
module dnn_input_buf
   import dnn_input_buf_pkg::*;
#(
   parameter int OBIT    = OBIT_DEF,
   parameter int INFRAME = INFRAME_DEF,
   parameter int IDIM    = IDIM_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dv_i,
   input  logic [OBIT-1:0]   vec_i,
   input  logic [IDX_W-1:0]  index_i,
   output logic              vec_rdy_o,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [OBIT-1:0]   rd_data_o,
   output logic              rd_dv_o,
   input  logic              rel_i,
   output logic              drop_o,
   output logic              err_o,
   output logic [1:0]        fill_o
);

   localparam int NVEC = INFRAME * IDIM;

   wstate_t           wstate_reg;
   logic [ADDR_W-1:0] wcnt_reg;
   logic              wr_bank_reg;
   logic              rd_bank_reg;
   logic [1:0]        full_reg;
   logic [1:0]        full_next;
   logic [1:0]        fill_reg;
   logic              drop_reg;
   logic              err_reg;
   logic              rd_dv_reg;
   logic              rd_sel_reg;   // bank that produced the most recent valid read
   logic              rd_seen_reg;  // a valid read has happened since reset

   logic [IDX_W-1:0]  exp_idx;
   logic              wr_en;
   logic              wr_done;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_ok;
   logic              rel_ok;
   logic [OBIT-1:0]   bank_q [2];

   // Index the stream must carry for the word at wcnt: (wcnt+1) mod NVEC.
   always_comb begin
      exp_idx = IDX_W'(wcnt_reg) + IDX_W'(1);
      if (wcnt_reg == ADDR_W'(NVEC - 1))
         exp_idx = '0;
   end

   // Decide whether the current stream word is stored and whether it closes the vector.
   always_comb begin
      wr_en   = 1'b0;
      wr_done = 1'b0;
      wr_addr = wcnt_reg;
      case (wstate_reg)
         W_IDLE: begin
            if (dv_i && index_i == IDX_W'(1) && !full_reg[wr_bank_reg]) begin
               wr_en   = 1'b1;
               wr_addr = '0;
            end
         end
         W_FILL: begin
            if (dv_i && index_i == exp_idx) begin
               wr_en   = 1'b1;
               wr_done = (wcnt_reg == ADDR_W'(NVEC - 1));
            end
         end
         default: ;
      endcase
   end

   // Read/release qualification and next bank-full flags; completion and release hit different banks.
   always_comb begin
      rd_ok  = rd_en_i && full_reg[rd_bank_reg] && (rd_addr_i < ADDR_W'(NVEC));
      rel_ok = rel_i && full_reg[rd_bank_reg];
      full_next = full_reg;
      if (wr_done)
         full_next[wr_bank_reg] = 1'b1;
      if (rel_ok)
         full_next[rd_bank_reg] = 1'b0;
   end

   // Write FSM: accept, drop or abort incoming vectors, with registered status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_reg  <= W_IDLE;
         wcnt_reg    <= '0;
         wr_bank_reg <= 1'b0;
         drop_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         drop_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (wstate_reg)
            W_IDLE: begin
               if (dv_i) begin
                  if (index_i == IDX_W'(1)) begin
                     if (!full_reg[wr_bank_reg]) begin
                        wstate_reg <= W_FILL;
                        wcnt_reg   <= ADDR_W'(1);
                     end else begin
                        // Write bank still full means both banks are full.
                        wstate_reg <= W_DROP;
                        drop_reg   <= 1'b1;
                     end
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            W_FILL: begin
               if (wr_en) begin
                  if (wr_done) begin
                     wr_bank_reg <= ~wr_bank_reg;
                     wcnt_reg    <= '0;
                     wstate_reg  <= W_IDLE;
                  end else begin
                     wcnt_reg <= wcnt_reg + ADDR_W'(1);
                  end
               end else begin
                  err_reg    <= 1'b1;
                  wcnt_reg   <= '0;
                  wstate_reg <= W_IDLE;
               end
            end
            W_DROP: begin
               if (!dv_i)
                  wstate_reg <= W_IDLE;
            end
            default: wstate_reg <= W_IDLE;
         endcase
      end
   end

   // Read side: bank-full flags, fill count, read pointer and read-valid tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_reg    <= '0;
         fill_reg    <= '0;
         rd_bank_reg <= 1'b0;
         rd_dv_reg   <= 1'b0;
         rd_sel_reg  <= 1'b0;
         rd_seen_reg <= 1'b0;
      end else begin
         full_reg  <= full_next;
         fill_reg  <= {1'b0, full_next[0]} + {1'b0, full_next[1]};
         rd_dv_reg <= rd_ok;
         if (rd_ok) begin
            rd_sel_reg  <= rd_bank_reg;
            rd_seen_reg <= 1'b1;
         end
         if (rel_ok)
            rd_bank_reg <= ~rd_bank_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         dnn_buf_bank #(
            .DEPTH(NVEC),
            .WIDTH(OBIT),
            .AW   (ADDR_W)
         ) u_bank (
            .clk    (clk),
            .wr_en  (wr_en && (wr_bank_reg == 1'(gi))),
            .wr_addr(wr_addr),
            .wr_data(vec_i),
            .rd_en  (rd_ok && (rd_bank_reg == 1'(gi))),
            .rd_addr(rd_addr_i),
            .rd_data(bank_q[gi])
         );
      end
   endgenerate

   assign vec_rdy_o = full_reg[rd_bank_reg];
   assign rd_dv_o   = rd_dv_reg;
   assign rd_data_o = rd_seen_reg ? bank_q[rd_sel_reg] : '0;
   assign drop_o    = drop_reg;
   assign err_o     = err_reg;
   assign fill_o    = fill_reg;

endmodule
